// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_checker
//  Purpose  : Self-synchronising serial checker for x^N + x^TAP + 1 PRBS
//             streams. Seeds itself from the incoming bits, declares lock
//             after LOCK_CNT consecutive correct predictions, then runs its
//             predictor free and counts bit errors and compared bits. Lock
//             is dropped when LOSS_ERRS errors land in one WIN-bit window,
//             and acquisition restarts automatically.
//  Ports    : clk        - rising-edge clock
//             reset_n    - asynchronous active-low reset
//             en         - data_in is valid this cycle
//             data_in    - received serial bit
//             clear      - synchronous restart (counters 0, back to ACQUIRE)
//             locked     - checker is in LOCKED
//             err_pulse  - one-cycle pulse per mismatched bit while locked
//             err_count  - saturating error count
//             bit_count  - saturating count of bits compared while locked
//             pass       - locked and no errors seen
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
    parameter int N         = 15,
    parameter int TAP       = 14,
    parameter int LOCK_CNT  = 32,
    parameter int WIN       = 64,
    parameter int LOSS_ERRS = 8,
    parameter int ERR_W     = 16,
    parameter int BIT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count,
    output logic             pass
);

    // Counter widths: each counter only needs to hold its terminal value - 1,
    // except the window error count which is compared at LOSS_ERRS.
    localparam int FC_W = $clog2(N);
    localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WE_W = $clog2(LOSS_ERRS + 1);

    localparam logic [FC_W-1:0]  FILL_LAST  = FC_W'(N - 1);
    localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [WC_W-1:0]  WIN_LAST   = WC_W'(WIN - 1);
    localparam logic [WE_W-1:0]  LOSS_LIM   = WE_W'(LOSS_ERRS);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [BIT_W-1:0] BIT_MAX    = {BIT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_SYNC    = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state,       state_nxt;
    logic [N:1]       sreg,        sreg_nxt;
    logic [FC_W-1:0]  fill_cnt,    fill_cnt_nxt;
    logic [MC_W-1:0]  match_cnt,   match_cnt_nxt;
    logic [WC_W-1:0]  win_cnt,     win_cnt_nxt;
    logic [WE_W-1:0]  win_errs,    win_errs_nxt;
    logic             locked_nxt;
    logic             err_pulse_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic [BIT_W-1:0] bit_count_nxt;

    logic             predicted;
    logic             mismatch;
    logic [WE_W-1:0]  errs_now;

    assign predicted = sreg[N] ^ sreg[TAP];
    assign mismatch  = data_in ^ predicted;
    // Window error count including the bit being checked right now.
    assign errs_now  = win_errs + WE_W'(mismatch);

    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        fill_cnt_nxt  = fill_cnt;
        match_cnt_nxt = match_cnt;
        win_cnt_nxt   = win_cnt;
        win_errs_nxt  = win_errs;
        locked_nxt    = locked;
        err_pulse_nxt = 1'b0;
        err_count_nxt = err_count;
        bit_count_nxt = bit_count;

        if (clear) begin
            state_nxt     = ST_ACQUIRE;
            sreg_nxt      = '0;
            fill_cnt_nxt  = '0;
            match_cnt_nxt = '0;
            win_cnt_nxt   = '0;
            win_errs_nxt  = '0;
            locked_nxt    = 1'b0;
            err_count_nxt = '0;
            bit_count_nxt = '0;
        end else if (en) begin
            // Once locked the predictor free-runs so received errors never
            // poison the reference sequence.
            sreg_nxt = {sreg[N-1:1], (state == ST_LOCKED) ? predicted : data_in};

            case (state)
                ST_ACQUIRE: begin
                    if (fill_cnt == FILL_LAST) begin
                        state_nxt     = ST_SYNC;
                        fill_cnt_nxt  = '0;
                        match_cnt_nxt = '0;
                    end else begin
                        fill_cnt_nxt = fill_cnt + FC_W'(1);
                    end
                end

                ST_SYNC: begin
                    // An all-zero register trivially predicts an all-zero
                    // stream; such matches must not build toward lock.
                    if (!mismatch && (sreg != '0)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt     = ST_LOCKED;
                            locked_nxt    = 1'b1;
                            match_cnt_nxt = '0;
                            win_cnt_nxt   = '0;
                            win_errs_nxt  = '0;
                        end else begin
                            match_cnt_nxt = match_cnt + MC_W'(1);
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end

                ST_LOCKED: begin
                    if (bit_count != BIT_MAX) begin
                        bit_count_nxt = bit_count + BIT_W'(1);
                    end
                    if (mismatch) begin
                        err_pulse_nxt = 1'b1;
                        if (err_count != ERR_MAX) begin
                            err_count_nxt = err_count + ERR_W'(1);
                        end
                    end
                    if (errs_now == LOSS_LIM) begin
                        state_nxt     = ST_ACQUIRE;
                        locked_nxt    = 1'b0;
                        fill_cnt_nxt  = '0;
                        match_cnt_nxt = '0;
                        win_cnt_nxt   = '0;
                        win_errs_nxt  = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        // An error on the closing bit was already judged
                        // against this window via errs_now above.
                        win_cnt_nxt  = '0;
                        win_errs_nxt = '0;
                    end else begin
                        win_cnt_nxt  = win_cnt + WC_W'(1);
                        win_errs_nxt = errs_now;
                    end
                end

                default: begin
                    state_nxt  = ST_ACQUIRE;
                    locked_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ACQUIRE;
            sreg      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            fill_cnt  <= fill_cnt_nxt;
            match_cnt <= match_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            win_errs  <= win_errs_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err_count <= err_count_nxt;
            bit_count <= bit_count_nxt;
        end
    end

    assign pass = locked && (err_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_checker
//  Purpose  : Self-checking bench for prbs_checker. A PRBS15 source feeds the
//             checker; a behavioural model tracks acquisition, lock, window
//             errors and counters from the received history.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    localparam int N        = 15;
    localparam int TAP      = 14;
    localparam int LOCK_CNT = 32;
    localparam int WIN      = 64;
    localparam int LOSS     = 8;
    localparam int ERR_MAX  = 65535;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        data_in = 1'b0;
    logic        clear = 1'b0;

    logic        locked, err_pulse, pass;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    logic        locked2, err_pulse2, pass2;
    logic [3:0]  err_count2;
    logic [31:0] bit_count2;

    logic [50:0] observed;
    assign observed = {locked, err_pulse, pass, err_count, bit_count};

    prbs_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .data_in   (data_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count),
        .pass      (pass)
    );

    prbs_checker #(.ERR_W(4), .WIN(64), .LOSS_ERRS(64)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .data_in   (data_in),
        .clear     (clear),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2),
        .bit_count (bit_count2),
        .pass      (pass2)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // ---------------- reference model ----------------
    int      m_mode;      // 0 acquire, 1 sync, 2 locked
    int      m_fill, m_match, m_since, m_werr, m_err;
    longint  m_bits;
    bit      m_pulse;
    bit      hist[$];     // reference history, newest at the back
    bit      gen[$];      // PRBS source history

    function automatic bit gen_bit();
        bit b;
        b = gen[gen.size()-N] ^ gen[gen.size()-TAP];
        gen.push_back(b);
        void'(gen.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_since = 0; m_werr = 0;
        m_err = 0; m_bits = 0; m_pulse = 0;
        hist.delete();
        repeat (N) hist.push_back(1'b0);
    endtask

    task automatic model_push(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic model_step(input bit e, input bit d, input bit c);
        bit pred, mism, nz;
        if (c) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (e) begin
                pred = hist[hist.size()-N] ^ hist[hist.size()-TAP];
                mism = (d != pred);
                nz = 0;
                foreach (hist[k]) if (hist[k]) nz = 1;
                if (m_mode == 0) begin
                    model_push(d);
                    m_fill++;
                    if (m_fill == N) begin m_mode = 1; m_fill = 0; m_match = 0; end
                end else if (m_mode == 1) begin
                    model_push(d);
                    if (!mism && nz) m_match++; else m_match = 0;
                    if (m_match == LOCK_CNT) begin
                        m_mode = 2; m_match = 0; m_since = 0; m_werr = 0;
                    end
                end else begin
                    model_push(pred);
                    m_bits++;
                    if (mism) begin
                        m_pulse = 1;
                        m_werr++;
                        if (m_err < ERR_MAX) m_err++;
                    end
                    if (m_werr >= LOSS) begin
                        m_mode = 0; m_fill = 0; m_match = 0;
                    end else begin
                        m_since++;
                        if (m_since % WIN == 0) m_werr = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [50:0] expected();
        bit lk;
        lk = (m_mode == 2);
        return {lk, m_pulse, lk && (m_err == 0), 16'(m_err), 32'(m_bits)};
    endfunction

    // Drive one cycle: inputs change #1 after an edge, outputs are sampled #1
    // after the following edge.
    task automatic step(input bit e, input bit d, input bit c);
        en = e; data_in = d; clear = c;
        @(posedge clk);
        #1;
        model_step(e, d, c);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (observed !== 51'd0) $display("FAIL reset_hold: got %h want 0", observed);
        else passed++;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (observed !== 51'd0) $display("FAIL reset_release: got %h want 0", observed);
        else passed++;
    endtask

    task automatic test_clean_lock();
        for (int i = 1; i <= 147; i++) begin
            step(1, gen_bit(), 0);
            total++;
            if (observed !== expected())
                $display("FAIL clean_lock bit %0d: got %h want %h", i, observed, expected());
            else passed++;
            if (i == 46) begin
                total++;
                if (locked !== 1'b0) $display("FAIL lock_early: locked=%b want 0", locked);
                else passed++;
            end
            if (i == 47) begin
                total++;
                if ({locked, pass} !== 2'b11) $display("FAIL lock_at_47: locked,pass=%b want 11", {locked, pass});
                else passed++;
            end
        end
        total++;
        if (bit_count !== 32'd100 || err_count !== 16'd0)
            $display("FAIL clean_counts: bits=%0d errs=%0d want 100/0", bit_count, err_count);
        else passed++;
    endtask

    task automatic test_single_error();
        bit b;
        b = gen_bit();
        step(1, ~b, 0);
        total++;
        if ({err_pulse, locked, pass, err_count} !== {1'b1, 1'b1, 1'b0, 16'd1})
            $display("FAIL single_err: pulse=%b lock=%b pass=%b errs=%0d want 1 1 0 1",
                     err_pulse, locked, pass, err_count);
        else passed++;
        step(1, gen_bit(), 0);
        total++;
        if (err_pulse !== 1'b0) $display("FAIL single_err_pulse_width: pulse=%b want 0", err_pulse);
        else passed++;
        for (int i = 0; i < 500; i++) begin
            step(1, gen_bit(), 0);
            total++;
            if (observed !== expected())
                $display("FAIL single_err_tail %0d: got %h want %h", i, observed, expected());
            else passed++;
        end
        total++;
        if (err_count !== 16'd1 || locked !== 1'b1)
            $display("FAIL single_err_final: errs=%0d lock=%b want 1 1", err_count, locked);
        else passed++;
    endtask

    task automatic relock();
        step(0, 0, 1);
        for (int i = 0; i < 47; i++) step(1, gen_bit(), 0);
        // Align to the start of a loss-of-lock window.
        for (int i = 0; i < WIN && (m_since % WIN) != 0; i++) step(1, gen_bit(), 0);
    endtask

    task automatic test_loss_of_lock();
        bit b;
        relock();
        total++;
        if (locked !== 1'b1) $display("FAIL loss_prelock: locked=%b want 1", locked);
        else passed++;
        for (int k = 0; k < 16; k++) begin
            b = gen_bit();
            step(1, (k % 2 == 1) ? ~b : b, 0);
            if (k == 13) begin
                total++;
                if (locked !== 1'b1) $display("FAIL loss_7th: locked=%b want 1", locked);
                else passed++;
            end
        end
        total++;
        if (locked !== 1'b0 || err_count !== 16'd8 || observed !== expected())
            $display("FAIL loss_8th: lock=%b errs=%0d got %h want %h", locked, err_count, observed, expected());
        else passed++;
        for (int i = 1; i <= 47; i++) begin
            step(1, gen_bit(), 0);
            if (i == 46 || i == 47) begin
                total++;
                if (locked !== (i == 47) || err_count !== 16'd8)
                    $display("FAIL relock bit %0d: lock=%b errs=%0d want %0d 8", i, locked, err_count, i == 47);
                else passed++;
            end
        end
        // 7 errors late in one window, 1 early in the next: lock holds.
        relock();
        for (int p = 0; p < WIN + 10; p++) begin
            b = gen_bit();
            step(1, ((p >= 50 && p <= 56) || p == WIN + 5) ? ~b : b, 0);
        end
        total++;
        if (locked !== 1'b1 || err_count !== 16'd8 || observed !== expected())
            $display("FAIL split_window: lock=%b errs=%0d want 1 8", locked, err_count);
        else passed++;
    endtask

    task automatic test_zero_one();
        step(0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            step(1, (i >= 300), 0);
            total++;
            if (locked !== 1'b0 || observed !== expected())
                $display("FAIL const_stream %0d: got %h want %h", i, observed, expected());
            else passed++;
        end
        for (int i = 1; i <= 47; i++) begin
            step(1, gen_bit(), 0);
            total++;
            if (observed !== expected())
                $display("FAIL const_relock %0d: got %h want %h", i, observed, expected());
            else passed++;
        end
        total++;
        if (locked !== 1'b1) $display("FAIL const_relock_47: locked=%b want 1", locked);
        else passed++;
    endtask

    task automatic test_random_en();
        int nb;
        bit e, b;
        logic [50:0] prev, idle;
        step(0, 0, 1);
        nb = 0;
        prev = observed;
        for (int c = 0; c < 4000 && nb < 147; c++) begin
            e = 1'($urandom_range(0, 1));
            b = e ? gen_bit() : 1'($urandom_range(0, 1));
            step(e, b, 0);
            if (e) nb++;
            total++;
            if (observed !== expected())
                $display("FAIL rand_en cyc %0d: got %h want %h", c, observed, expected());
            else passed++;
            if (!e) begin
                idle = prev;
                idle[49] = 1'b0;
                total++;
                if (observed !== idle) $display("FAIL rand_en_idle cyc %0d: got %h want %h", c, observed, idle);
                else passed++;
            end else if (nb == 46 || nb == 47) begin
                total++;
                if (locked !== (nb == 47)) $display("FAIL rand_en_lock bit %0d: locked=%b", nb, locked);
                else passed++;
            end
            prev = observed;
        end
        total++;
        if (nb != 147 || bit_count !== 32'd100 || err_count !== 16'd0)
            $display("FAIL rand_en_counts: en_bits=%0d bits=%0d errs=%0d want 147 100 0", nb, bit_count, err_count);
        else passed++;
    endtask

    task automatic test_clear();
        bit b;
        relock();
        for (int k = 0; k < 7; k++) begin
            b = gen_bit();
            step(1, (k % 3 == 0) ? ~b : b, 0);
        end
        total++;
        if (err_count !== 16'd3 || locked !== 1'b1)
            $display("FAIL clear_setup: errs=%0d lock=%b want 3 1", err_count, locked);
        else passed++;
        step(1, gen_bit(), 1);
        total++;
        if (observed !== 51'd0) $display("FAIL clear_zero: got %h want 0", observed);
        else passed++;
        for (int i = 1; i <= 47; i++) begin
            step(1, gen_bit(), 0);
            if (i >= 46) begin
                total++;
                if (locked !== (i == 47) || observed !== expected())
                    $display("FAIL clear_relock %0d: got %h want %h", i, observed, expected());
                else passed++;
            end
        end
    endtask

    task automatic test_err_saturation();
        bit b;
        relock();
        for (int k = 1; k <= 20; k++) begin
            b = gen_bit();
            step(1, ~b, 0);
            if (k == 14) begin
                total++;
                if (err_count2 !== 4'd14) $display("FAIL sat_14: errs=%0d want 14", err_count2);
                else passed++;
            end
        end
        total++;
        if (err_count2 !== 4'd15 || locked2 !== 1'b1)
            $display("FAIL sat_hold: errs=%0d lock=%b want 15 1", err_count2, locked2);
        else passed++;
    endtask

    task automatic test_async_reset();
        bit b;
        relock();
        b = gen_bit(); step(1, ~b, 0);
        b = gen_bit(); step(1, b, 0);
        b = gen_bit(); step(1, ~b, 0);
        total++;
        if (err_count !== 16'd2 || locked !== 1'b1)
            $display("FAIL areset_setup: errs=%0d lock=%b want 2 1", err_count, locked);
        else passed++;
        en = 1'b1; data_in = gen_bit();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (observed !== 51'd0 || {locked2, err_pulse2, pass2, err_count2, bit_count2} !== 39'd0)
            $display("FAIL areset_immediate: got %h want 0", observed);
        else passed++;
        en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 47; i++) begin
            step(1, gen_bit(), 0);
            total++;
            if (observed !== expected())
                $display("FAIL areset_relock %0d: got %h want %h", i, observed, expected());
            else passed++;
        end
        total++;
        if (locked !== 1'b1) $display("FAIL areset_lock47: locked=%b want 1", locked);
        else passed++;
    endtask

    initial begin
        gen.delete();
        repeat (N) gen.push_back(1'b1);   // seed 15'h7FFF
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_zero_one();
        test_random_en();
        test_clear();
        test_err_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
